dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl_if.sv | 24 ++
 rtl/dmem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the core load/store path and dmem_ctrl.
// The core drives the master side; dmem_ctrl implements the slave side.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Multi-cycle data memory with byte/half/word access and wait states.
// Requests are accepted in IDLE, held for WAIT_STATES cycles in BUSY,
// performed at the last BUSY edge and reported by a one-cycle RESP pulse.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses are
// rejected with rsp_err instead of being forced to alignment.
module dmem_ctrl #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    dmem_ctrl_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_uns;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic          out_of_range;
    logic          bad_size;
    logic          misaligned;
    logic          acc_err;
    logic [1:0]    lane;
    logic [31:0]   cur_word;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic [31:0]   wrep;
    logic [3:0]    byte_en;
    logic [31:0]   merged;
    logic          do_access;
    logic          mem_we;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    assign word_idx  = cap_addr[AW+1:2];
    assign cur_word  = mem[word_idx];
    assign do_access = (state == BUSY) && (cnt == 4'd0);
    assign mem_we    = do_access && cap_we && !acc_err;

    // Decode the captured request: error checks, lane selection, load/store data.
    always_comb begin
        out_of_range = (cap_addr >> (AW + 2)) != 32'd0;
        bad_size     = (cap_size == 2'b11);
        misaligned   = ((cap_size == 2'b01) && cap_addr[0]) ||
                       ((cap_size == 2'b10) && (cap_addr[1:0] != 2'b00));
`ifdef MISALIGN_TRAP_EN
        acc_err      = out_of_range || bad_size || misaligned;
`else
        acc_err      = out_of_range || bad_size;
`endif

        // Half ignores addr[0] and word ignores addr[1:0]; with trapping enabled
        // any misaligned access errors out, so the forced lane is never used.
        case (cap_size)
            2'b00:   lane = cap_addr[1:0];
            2'b01:   lane = {cap_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase

        shifted = cur_word >> {lane, 3'b000};
        case (cap_size)
            2'b00:   load_data = cap_uns ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = cap_uns ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase

        case (cap_size)
            2'b00: begin
                wrep    = {4{cap_wdata[7:0]}};
                byte_en = 4'b0001 << lane;
            end
            2'b01: begin
                wrep    = {2{cap_wdata[15:0]}};
                byte_en = 4'b0011 << lane;
            end
            default: begin
                wrep    = cap_wdata;
                byte_en = 4'b1111;
            end
        endcase

        merged = cur_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[i*8 +: 8] = wrep[i*8 +: 8];
        end
    end

    // Storage array: cleared by reset, read-modify-write on a committed store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[word_idx] <= merged;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cap_we      <= 1'b0;
            cap_size    <= '0;
            cap_uns     <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    if (bus.req_valid) begin
                        cap_we      <= bus.req_we;
                        cap_size    <= bus.req_size;
                        cap_uns     <= bus.req_unsigned;
                        cap_addr    <= bus.req_addr;
                        cap_wdata   <= bus.req_wdata;
                        cnt         <= 4'(WAIT_STATES);
                        req_ready_q <= 1'b0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                        rsp_rdata_q <= (cap_we || acc_err) ? '0 : load_data;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with WAIT_STATES=0, one with 3.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    logic rst0;
    logic rst3;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_ctrl_if bus0 ();
    dmem_ctrl_if bus3 ();

    dmem_ctrl #(.DEPTH(64), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
    dmem_ctrl #(.DEPTH(64), .WAIT_STATES(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit w3, input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
        if (w3) begin
            bus3.req_valid = v; bus3.req_we = we; bus3.req_size = sz;
            bus3.req_unsigned = uns; bus3.req_addr = a; bus3.req_wdata = d;
        end else begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_size = sz;
            bus0.req_unsigned = uns; bus0.req_addr = a; bus0.req_wdata = d;
        end
    endtask

    function automatic logic [34:0] outs(input bit w3);
        // {ready, valid, err, rdata}
        if (w3) return {bus3.req_ready, bus3.rsp_valid, bus3.rsp_err, bus3.rsp_rdata};
        return {bus0.req_ready, bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata};
    endfunction

    // One transaction; checks latency, returns response data/error.
    task automatic txn(input string tag, input bit w3, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        int lat;
        logic [34:0] o;
        @(negedge clk);
        drive(w3, 1'b1, we, sz, uns, a, d);
        @(posedge clk);
        #1 drive(w3, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        lat = -1; rd = '0; er = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            o = outs(w3);
            if (o[33]) begin
                lat = i; rd = o[31:0]; er = o[32];
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), w3 ? 32'd5 : 32'd2);
    endtask

    task automatic load(input string tag, input bit w3, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] rd;
        logic er;
        txn(tag, w3, 1'b0, sz, uns, a, 32'h0, rd, er);
        check({tag, "_data"}, rd, exp_d);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_e});
    endtask

    task automatic store(input string tag, input bit w3, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input logic exp_e);
        logic [31:0] rd;
        logic er;
        txn(tag, w3, 1'b1, sz, 1'b0, a, d, rd, er);
        check({tag, "_data"}, rd, 32'h0);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_e});
    endtask

    initial begin
        logic [34:0] o;
        logic [5:0]  rdy_pat;
        logic [5:0]  vld_pat;
        logic        seen;

        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;
        o = outs(1'b0);
        check("reset_ctl0", {29'd0, o[34:32]}, 32'h4);
        check("reset_rdata0", o[31:0], 32'h0);
        o = outs(1'b1);
        check("reset_ctl3", {29'd0, o[34:32]}, 32'h4);

        // Word store / load round trip
        store("sw10", 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
        load("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        // Response fields return to zero once back in IDLE
        @(negedge clk);
        o = outs(1'b0);
        check("idle_after_rsp", o[34:0] == {1'b1, 2'b00, 32'h0} ? 32'h1 : 32'h0, 32'h1);

        // Byte store, byte loads with and without sign extension
        store("sb11", 1'b0, 2'b00, 32'h11, 32'h0000005A, 1'b0);
        load("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEAD5AEF, 1'b0);
        load("lb11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0000005A, 1'b0);
        load("lb13", 1'b0, 2'b00, 1'b0, 32'h13, 32'hFFFFFFDE, 1'b0);
        load("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h000000DE, 1'b0);

        // Halfword store and loads
        store("sh12", 1'b0, 2'b01, 32'h12, 32'h00008001, 1'b0);
        load("lh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'hFFFF8001, 1'b0);
        load("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h00008001, 1'b0);
        load("lw10c", 1'b0, 2'b10, 1'b1, 32'h10, 32'h80015AEF, 1'b0);

        // Range and size errors
        load("lw100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
        store("sw100", 1'b0, 2'b10, 32'h100, 32'h12345678, 1'b1);
        load("lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        load("ld_sz11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1);
        store("st_sz11", 1'b0, 2'b11, 32'h10, 32'hFFFFFFFF, 1'b1);
        load("lw10d", 1'b0, 2'b10, 1'b0, 32'h10, 32'h80015AEF, 1'b0);

        // Last word in range
        store("swfc", 1'b0, 2'b10, 32'hFC, 32'hCAFEF00D, 1'b0);
        load("lwfc", 1'b0, 2'b10, 1'b0, 32'hFC, 32'hCAFEF00D, 1'b0);

        // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
        load("lh11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1);
        store("sw13", 1'b0, 2'b10, 32'h13, 32'h11223344, 1'b1);
        load("lw10e", 1'b0, 2'b10, 1'b0, 32'h10, 32'h80015AEF, 1'b0);
`else
        load("lh11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h00005AEF, 1'b0);
        store("sw13", 1'b0, 2'b10, 32'h13, 32'h11223344, 1'b0);
        load("lw10e", 1'b0, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0);
`endif

        // WAIT_STATES=3: ready/valid timing after accept
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5A5A5);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            o = outs(1'b1);
            rdy_pat[i] = o[34];
            vld_pat[i] = o[33];
        end
        check("ws3_ready_pat", {26'd0, rdy_pat}, 32'h20);
        check("ws3_valid_pat", {26'd0, vld_pat}, 32'h10);
        load("ws3_lw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5A5A5, 1'b0);

        // Reset in the second BUSY cycle aborts the store
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h13579BDF);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            o = outs(1'b1);
            seen = seen | o[33];
        end
        check("abort_no_rsp", {31'd0, seen}, 32'h0);
        check("abort_ready", {31'd0, o[34]}, 32'h1);
        load("abort_lw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        load("abort_lw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
